rr_arb_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and a single output register stage. It selects a source either by an external select (fixed mode) or by round-robin arbitration among valid channels. It replaces ad-hoc combinational selects where several pipeline producers share one consumer, such as writeback or forwarding sources feeding a shared stage. Latency is one cycle, and throughput is one transfer per cycle.

---
 rtl/rr_arb_mux.sv | 110 +++++++++++
 tb/tb_rr_arb_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux
// Registered N-to-1 multiplexer with per-channel valid/ready handshakes.
// A source is picked either by an external select (fixed mode) or by
// round-robin arbitration among the valid channels. One output register
// stage gives one cycle of latency and one transfer per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel used in fixed mode (values >= N never grant)
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (combinational, at most one bit set)
//   out_data   registered selected data
//   out_src    registered index of the channel that supplied out_data
//   out_valid  output register holds data
//   out_ready  consumer takes out_data this cycle
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic             load_en;
  logic             xfer;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW:0]    rr_idx;

  // The register can accept a word when empty or when it is being drained.
  assign load_en = !out_valid || out_ready;

  // Grant selection. The round-robin search walks offsets from N-1 down to
  // 0 so that the last hit written is the first valid channel at or after
  // ptr in wrap order. The index sum carries one extra bit so ptr+k never
  // overflows before the modulo-N correction.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        rr_idx = {1'b0, ptr} + (SELW + 1)'(k);
        if (rr_idx >= (SELW + 1)'(N)) begin
          rr_idx = rr_idx - (SELW + 1)'(N);
        end
        if (in_valid[rr_idx[SELW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = rr_idx[SELW-1:0];
        end
      end
    end else if ({1'b0, sel} < (SELW + 1)'(N)) begin
      gnt_valid = in_valid[sel];
      gnt_idx   = sel;
    end
  end

  // One-hot accept; also picks the granted channel's data word.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en && gnt_valid && (gnt_idx == SELW'(i));
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer     = |in_ready;
  assign ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // Output register and round-robin pointer. A transfer always wins over a
  // drain, so a simultaneous drain and load keeps out_valid high. The
  // pointer only advances on round-robin transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_src   <= gnt_idx;
      if (mode) begin
        ptr <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux
// Directed and randomized checks of rr_arb_mux. A 4-channel instance is
// compared every cycle against a behavioural model (pointer, output word,
// valid flag); a 6-channel instance covers out-of-range select values.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic        mode6;
  logic [2:0]  sel6;
  logic [95:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic [15:0] out_data6;
  logic [2:0]  out_src6;
  logic        out_valid6;
  logic        out_ready6;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mptr;
  bit          mval;
  logic [15:0] mdata;
  int          msrc;
  logic [15:0] chd [4];
  logic [15:0] saved;

  rr_arb_mux #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(16), .N(6)) dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .sel(sel6), .in_data(in_data6),
    .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
    .out_src(out_src6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected grant: fixed mode takes sel if valid; round-robin takes the
  // lowest valid channel at or above ptr, otherwise the lowest valid one.
  function automatic int exp_gnt(input bit md, input int s, input logic [3:0] v,
                                 input int p, output bit gv);
    int best;
    best = -1;
    if (!md) begin
      if (s < 4 && v[s]) best = s;
    end else begin
      for (int i = 0; i < 4; i++) if (v[i] && i >= p && best < 0) best = i;
      for (int i = 0; i < 4; i++) if (v[i] && best < 0) best = i;
    end
    gv = (best >= 0);
    return (best < 0) ? 0 : best;
  endfunction

  task automatic applyStimulus(input bit md, input int s, input logic [3:0] v, input bit r);
    mode      = md;
    sel       = 2'(s);
    in_valid  = v;
    out_ready = r;
    in_data   = {chd[3], chd[2], chd[1], chd[0]};
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int gi;
    bit gv;
    logic [3:0] er;
    gi = exp_gnt(mode, int'(sel), in_valid, mptr, gv);
    er = ((!mval || out_ready) && gv) ? 4'(1 << gi) : 4'b0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mval));
    chk({tag, ".out_data"}, 64'(out_data), 64'(mdata));
    chk({tag, ".out_src"}, 64'(out_src), 64'(msrc));
  endtask

  // Advance one clock and update the model from the inputs held across it.
  task automatic tick();
    int gi;
    bit gv;
    bit ld;
    gi = exp_gnt(mode, int'(sel), in_valid, mptr, gv);
    ld = !mval || out_ready;
    @(posedge clk);
    if (ld && gv) begin
      mdata = chd[gi];
      msrc  = gi;
      mval  = 1'b1;
      if (mode) mptr = (gi + 1) % 4;
    end else if (out_ready) begin
      mval = 1'b0;
    end
    #1;
  endtask

  task automatic modelReset();
    mptr  = 0;
    mval  = 1'b0;
    mdata = '0;
    msrc  = 0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) chd[i] = '0;
    modelReset();
    mode6 = 1'b0; sel6 = '0; in_data6 = '0; in_valid6 = '0; out_ready6 = 1'b0;
    applyStimulus(1'b0, 0, 4'b0000, 1'b0);
    #1;
    checkOutput("reset");
    chk("reset.out_valid6", 64'(out_valid6), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fixed mode on both instances
    chd[0] = 16'h1111; chd[1] = 16'h2222; chd[2] = 16'hBEEF; chd[3] = 16'h4444;
    sel6 = 3'd5; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    in_data6 = {16'hCAFE, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    applyStimulus(1'b0, 2, 4'b1111, 1'b1);
    checkOutput("fix_sel2");
    chk("fix.in_ready_const", 64'(in_ready), 64'(4'b0100));
    chk("fix6.in_ready_sel5", 64'(in_ready6), 64'(6'b100000));
    tick();
    chk("fix.out_data_const", 64'(out_data), 64'(16'hBEEF));
    chk("fix.out_src_const", 64'(out_src), 64'(2));
    chk("fix6.out_data", 64'(out_data6), 64'(16'hCAFE));
    chk("fix6.out_src", 64'(out_src6), 64'(5));
    sel6 = 3'd7;
    applyStimulus(1'b0, 2, 4'b1011, 1'b1);
    checkOutput("fix_invalid");
    chk("fix.in_ready_zero", 64'(in_ready), 64'(0));
    chk("fix6.in_ready_sel7", 64'(in_ready6), 64'(0));
    tick();
    chk("fix.out_valid_drop", 64'(out_valid), 64'(0));
    chk("fix6.out_valid_drop", 64'(out_valid6), 64'(0));
    sel6 = 3'd6;
    #1;
    chk("fix6.in_ready_sel6", 64'(in_ready6), 64'(0));

    // Round-robin fairness with all channels valid
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 0, 4'b1111, 1'b1);
      checkOutput("rr_fair");
      tick();
      chk("rr_fair.src_seq", 64'(out_src), 64'(c % 4));
      chk("rr_fair.no_bubble", 64'(out_valid), 64'(1));
    end

    // Skip and wrap: grant 2 leaves ptr at 3, then only 0 and 1 valid
    applyStimulus(1'b1, 0, 4'b0100, 1'b1);
    checkOutput("rr_ch2");
    tick();
    applyStimulus(1'b1, 0, 4'b0011, 1'b1);
    checkOutput("rr_wrap");
    chk("rr_wrap.rdy0", 64'(in_ready), 64'(4'b0001));
    tick();
    chk("rr_wrap.src0", 64'(out_src), 64'(0));
    applyStimulus(1'b1, 0, 4'b0011, 1'b1);
    chk("rr_wrap.rdy1", 64'(in_ready), 64'(4'b0010));
    tick();
    chk("rr_wrap.src1", 64'(out_src), 64'(1));

    // Fixed-mode interlude must not move the pointer (left at 2)
    for (int s = 0; s < 4; s++) begin
      if (s == 2) continue;
      applyStimulus(1'b0, s, 4'b1111, 1'b1);
      checkOutput("mode_sw_fixed");
      tick();
    end
    applyStimulus(1'b1, 0, 4'b1111, 1'b1);
    checkOutput("mode_sw_rr");
    chk("mode_sw.ptr_kept", 64'(in_ready), 64'(4'b0100));
    tick();

    // Backpressure: word from channel 2 must stay put for five cycles
    saved = out_data;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) chd[i] = 16'($urandom);
      applyStimulus(1'b1, 0, 4'b1111, 1'b0);
      checkOutput("bp_hold");
      chk("bp.in_ready_zero", 64'(in_ready), 64'(0));
      tick();
      chk("bp.data_stable", 64'(out_data), 64'(saved));
      chk("bp.src_stable", 64'(out_src), 64'(2));
    end
    applyStimulus(1'b1, 0, 4'b1111, 1'b1);
    checkOutput("bp_release");
    chk("bp.release_rdy", 64'(in_ready), 64'(4'b1000));
    tick();
    chk("bp.release_valid", 64'(out_valid), 64'(1));
    chk("bp.release_src", 64'(out_src), 64'(3));

    // Asynchronous reset mid-stream while holding a word
    rst = 1'b1;
    #1;
    modelReset();
    chk("mid_rst.out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst.out_data", 64'(out_data), 64'(0));
    chk("mid_rst.out_src", 64'(out_src), 64'(0));
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 0, 4'b1111, 1'b1);
    checkOutput("post_rst");
    chk("post_rst.grant0", 64'(in_ready), 64'(4'b0001));
    tick();
    chk("post_rst.src0", 64'(out_src), 64'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) chd[i] = 16'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    4'($urandom), ($urandom_range(0, 3) != 0));
      checkOutput("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
